// File: rtl/conv_sequencer_if.sv
// Command/status bundle between a layer controller (master) and conv_sequencer (slave).
// Defining CONV_SEQ_PERF_EN adds the cycle_count status field.
interface conv_sequencer_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int BRAM_COUNT = 3
);
  logic                  start;
  logic [1:0]            mode;
  logic                  relu_en;
  logic [ADDR_WIDTH-1:0] length;
  logic [1:0]            dst_bank;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic                  ce;
  logic [31:0]           cell_ctrl;
  logic [ADDR_WIDTH-1:0] cell_mem_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [BRAM_COUNT-1:0] mem_we;
  logic                  ssa_sel;
  logic                  relu_bypass_sel;
  logic                  pool_sel;
`ifdef CONV_SEQ_PERF_EN
  logic [15:0]           cycle_count;
`endif

  modport master (
    output start, mode, relu_en, length, dst_bank, hold,
    input  busy, done, ce, cell_ctrl, cell_mem_addr, rd_addr, wr_addr, mem_we,
    input  ssa_sel, relu_bypass_sel, pool_sel
`ifdef CONV_SEQ_PERF_EN
    , input cycle_count
`endif
  );

  modport slave (
    input  start, mode, relu_en, length, dst_bank, hold,
    output busy, done, ce, cell_ctrl, cell_mem_addr, rd_addr, wr_addr, mem_we,
    output ssa_sel, relu_bypass_sel, pool_sel
`ifdef CONV_SEQ_PERF_EN
    , output cycle_count
`endif
  );
endinterface

// File: rtl/conv_sequencer.sv
// Layer sequencer for the conv/pool datapath: weight load, activation streaming, write-back.
// Defining CONV_SEQ_PERF_EN adds a saturating busy-cycle counter (cycle_count).
module conv_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int BRAM_COUNT = 3,
  parameter int PIPE_LAT   = 4,
  parameter int WLOAD_CYC  = 3
) (
  input logic             clk,
  input logic             rst,
  conv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] LOAD_LAST  = ADDR_WIDTH'(WLOAD_CYC - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(PIPE_LAT - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [1:0]            bank_q, bank_d;
  logic                  ssa_q, ssa_d;
  logic                  byp_q, byp_d;
  logic                  pool_q, pool_d;
  logic [PIPE_LAT-1:0]   pipe_q, pipe_d;
  logic                  busy, issue, wrFire;

  assign busy   = (state_q == LOAD) || (state_q == STREAM) || (state_q == DRAIN);
  assign wrFire = busy && !bus.hold && pipe_q[PIPE_LAT-1];

  // Next-state: every busy state freezes entirely while hold is high.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    len_d   = len_q;
    bank_d  = bank_q;
    ssa_d   = ssa_q;
    byp_d   = byp_q;
    pool_d  = pool_q;
    pipe_d  = pipe_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d  = bus.length;
          bank_d = bus.dst_bank;
          ssa_d  = (bus.mode == 2'b01);
          byp_d  = ~bus.relu_en;
          pool_d = (bus.mode == 2'b10);
          cnt_d  = '0;
          rd_d   = '0;
          wr_d   = '0;
          pipe_d = '0;
          if (bus.length == '0)       state_d = DONE;
          else if (bus.mode == 2'b10) state_d = STREAM;
          else                        state_d = LOAD;
        end
      end
      LOAD: begin
        if (!bus.hold) begin
          if (cnt_q == LOAD_LAST) begin
            cnt_d   = '0;
            state_d = STREAM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (!bus.hold) begin
          issue = 1'b1;
          rd_d  = rd_q + 1'b1;
          if (rd_q == len_q - 1'b1) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!bus.hold) begin
          if (cnt_q == DRAIN_LAST) state_d = DONE;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (busy && !bus.hold) pipe_d = PIPE_LAT'({pipe_q, issue});
    if (wrFire)            wr_d   = wr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      len_q   <= '0;
      bank_q  <= '0;
      ssa_q   <= 1'b0;
      byp_q   <= 1'b0;
      pool_q  <= 1'b0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      bank_q  <= bank_d;
      ssa_q   <= ssa_d;
      byp_q   <= byp_d;
      pool_q  <= pool_d;
      pipe_q  <= pipe_d;
    end
  end

  // Accumulator clear fires on the final un-held LOAD cycle only.
  assign bus.busy            = busy;
  assign bus.done            = (state_q == DONE);
  assign bus.ce              = busy && !bus.hold;
  assign bus.cell_ctrl       = {30'd0, (state_q == LOAD), (state_q == LOAD) && (cnt_q == LOAD_LAST) && !bus.hold};
  assign bus.cell_mem_addr   = (state_q == LOAD) ? cnt_q : '0;
  assign bus.rd_addr         = rd_q;
  assign bus.wr_addr         = wr_q;
  assign bus.ssa_sel         = ssa_q;
  assign bus.relu_bypass_sel = byp_q;
  assign bus.pool_sel        = pool_q;

  always_comb begin
    bus.mem_we = '0;
    for (int i = 0; i < BRAM_COUNT; i++) begin
      bus.mem_we[i] = wrFire && (bank_q == 2'(i));
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && bus.start)  cyc_d = '0;
    else if (busy && cyc_q != 16'hFFFF) cyc_d = cyc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign bus.cycle_count = cyc_q;
`endif
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: activation-memory and cell-memory address width.
REQ-002 Parameter BRAM_COUNT, default 3: number of activation-memory banks.
REQ-003 Parameter PIPE_LAT, default 4: cycles from a read address to its result at the memory write port.
REQ-004 Parameter WLOAD_CYC, default 3: weight-load cycles per layer.
REQ-005 Port clk  in  1: single clock, all logic on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous and active-high.
REQ-007 Port start  in  1: layer-start request, sampled only in IDLE.
REQ-008 Port mode  in  2: 00 conv 3x3; 01 conv 3x1; 10 max-pool; 11 reserved (treated as 00).
REQ-009 Port relu_en  in  1: 1 routes the result through ReLU, 0 bypasses it.
REQ-010 Port length  in  ADDR_WIDTH: number of output elements N.
REQ-011 Port dst_bank  in  2: destination bank index, 0..BRAM_COUNT-1.
REQ-012 Port hold  in  1: stall request.
REQ-013 Port busy  out  1: layer in progress.
REQ-014 Port done  out  1: one-cycle completion pulse.
REQ-015 Port ce  out  1: datapath clock enable.
REQ-016 Port cell_ctrl  out  32: bit0 accumulator clear, bit1 weight load, bits 31:2 always 0.
REQ-017 Port cell_mem_addr  out  ADDR_WIDTH: weight ROM address.
REQ-018 Port rd_addr, wr_addr  out  ADDR_WIDTH each: activation-memory read and write addresses.
REQ-019 Port mem_we  out  BRAM_COUNT: one-hot bank write enable.
REQ-020 Ports ssa_sel, relu_bypass_sel, pool_sel  out  1 each: datapath mux selects.

Function
REQ-021 FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE to LOAD on start=1 with mode≠10 and N≠0.
- IDLE to STREAM on start=1 with mode=10 and N≠0.
- IDLE to DONE on start=1 with N=0.
REQ-022 LOAD:
- lasts WLOAD_CYC cycles; cell_ctrl[1]=1; cell_mem_addr counts 0..WLOAD_CYC-1.
- on exit, cell_ctrl[0]=1 for exactly one cycle.
REQ-023 STREAM:
- lasts N cycles; rd_addr counts 0..N-1, one per cycle.
- then DRAIN for PIPE_LAT cycles, then DONE for one cycle (done=1), then IDLE.
REQ-024 Writes:
- the read issued at cycle t produces mem_we[dst_bank]=1 at cycle t+PIPE_LAT.
- wr_addr starts at 0 and increments after each write; exactly N writes per layer.
REQ-025 busy=1 in LOAD, STREAM and DRAIN; 0 in IDLE and DONE.
REQ-026 ce=1 in LOAD, STREAM and DRAIN while hold=0; 0 otherwise.
REQ-027 mode, relu_en, length and dst_bank are captured on the start cycle; later input changes have no effect until the next start.
REQ-028 Mux selects, constant for the whole layer:
- ssa_sel = (mode==01).
- relu_bypass_sel = ~relu_en.
- pool_sel = (mode==10).
REQ-029 hold=1 in a busy state freezes the FSM, all counters and the write pipeline; mem_we=0 during the hold. Operation resumes unchanged when hold returns to 0.
REQ-030 start while busy or in DONE is ignored; no queueing.
REQ-031 dst_bank ≥ BRAM_COUNT: the layer runs normally with mem_we all zero.
REQ-032 Addresses never wrap: N ≤ 2^ADDR_WIDTH-1 by width.

Reset
REQ-033 rst=1 at any cycle, including mid-layer, forces on the next edge:
- state to IDLE;
- all counters and the write pipeline to 0;
- every output to 0, including busy, done, ce, mem_we, cell_ctrl, all addresses and all selects.
REQ-034 A write pending at reset is discarded.

Configuration
REQ-035 Macro CONV_SEQ_PERF_EN, when defined, adds output cycle_count (16 bits):
- cleared on start;
- increments on every cycle with busy=1, including held cycles;
- saturates at 0xFFFF;
- holds its value in IDLE;
- reset value 0.
REQ-036 Without CONV_SEQ_PERF_EN the cycle_count port and its logic are absent; all other behaviour is identical.

Verification
REQ-037 mode=00, N=5, dst_bank=1, relu_en=1, start at cycle 0:
- busy rises at cycle 1; LOAD spans 3 cycles; rd_addr 0..4;
- mem_we=3'b010 on 5 cycles with wr_addr 0..4;
- done pulses once at cycle 1+3+5+4=13; relu_bypass_sel=0.
REQ-038 mode=10, N=3:
- no LOAD; cell_ctrl stays 0; pool_sel=1;
- done at cycle 1+3+4=8.
REQ-039 N=0, start:
- done=1 on the next cycle; busy, ce and mem_we never assert.
REQ-040 hold=1 for 2 cycles mid-STREAM:
- ce=0 and mem_we=0 for those 2 cycles;
- rd_addr frozen; done delayed by exactly 2 cycles.
REQ-041 rst pulsed during DRAIN:
- all outputs 0 on the next cycle; no further mem_we;
- a new start then runs the layer correctly.
REQ-042 With CONV_SEQ_PERF_EN and the REQ-037 run, cycle_count=12 after done.
